// File: rtl/gan_bias_seq.sv
// gan_bias_seq: bias-fetch sequencer. Latches a bias-set choice on start,
// drives the bias memory select and streams bias words layer by layer
// (G_L2, G_L3, D_L2, D_L3) over a valid/ready handshake with layer/index tags.
module gan_bias_seq #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned N_G_L2 = 3,
    parameter int unsigned N_G_L3 = 9,
    parameter int unsigned N_D_L2 = 3,
    parameter int unsigned N_D_L3 = 1,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sel_in,
    input  logic [1:0]              mode,
    input  logic                    abort,
    input  logic [N_G_L2*WIDTH-1:0] bg2,
    input  logic [N_G_L3*WIDTH-1:0] bg3,
    input  logic [N_D_L2*WIDTH-1:0] bd2,
    input  logic [N_D_L3*WIDTH-1:0] bd3,
    output logic                    mem_choice,
    output logic [WIDTH-1:0]        bias_data,
    output logic                    bias_valid,
    input  logic                    bias_ready,
    output logic [1:0]              bias_layer,
    output logic [IDX_W-1:0]        bias_idx,
    output logic                    layer_last,
    output logic                    seq_last,
    output logic                    busy,
    output logic                    done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] L_G2 = 2'd0;
    localparam logic [1:0] L_G3 = 2'd1;
    localparam logic [1:0] L_D2 = 2'd2;
    localparam logic [1:0] L_D3 = 2'd3;

    localparam logic [1:0] M_FULL = 2'b00;
    localparam logic [1:0] M_GEN  = 2'b01;
    localparam logic [1:0] M_DIS  = 2'b10;

    logic [1:0]       state;
    logic [1:0]       mode_r;
    logic             hs;
    logic [1:0]       first_layer;
    logic [1:0]       final_layer;
    logic [1:0]       nxt_layer;
    logic [IDX_W-1:0] nxt_idx;
    logic [IDX_W-1:0] nxt_last_idx;
    logic             nxt_layer_last;
    logic             nxt_seq_last;
    logic [WIDTH-1:0] nxt_word;

    // Next word position: first word of the mode in LOAD, otherwise the
    // successor of the word currently presented.
    always_comb begin
        hs          = bias_valid & bias_ready;
        first_layer = (mode_r == M_DIS) ? L_D2 : L_G2;
        final_layer = (mode_r == M_GEN) ? L_G3 : L_D3;
        nxt_layer   = bias_layer;
        nxt_idx     = bias_idx + IDX_W'(1);
        if (state == S_LOAD) begin
            nxt_layer = first_layer;
            nxt_idx   = '0;
        end else if (layer_last) begin
            nxt_layer = bias_layer + 2'd1;
            nxt_idx   = '0;
        end
        case (nxt_layer)
            L_G2:    nxt_last_idx = IDX_W'(N_G_L2 - 1);
            L_G3:    nxt_last_idx = IDX_W'(N_G_L3 - 1);
            L_D2:    nxt_last_idx = IDX_W'(N_D_L2 - 1);
            default: nxt_last_idx = IDX_W'(N_D_L3 - 1);
        endcase
        nxt_layer_last = (nxt_idx == nxt_last_idx);
        nxt_seq_last   = nxt_layer_last && (nxt_layer == final_layer);
    end

    // Select the next bias word from the packed memory buses.
    always_comb begin
        nxt_word = '0;
        case (nxt_layer)
            L_G2: begin
                for (int unsigned i = 0; i < N_G_L2; i++)
                    if (nxt_idx == IDX_W'(i)) nxt_word = bg2[i*WIDTH +: WIDTH];
            end
            L_G3: begin
                for (int unsigned i = 0; i < N_G_L3; i++)
                    if (nxt_idx == IDX_W'(i)) nxt_word = bg3[i*WIDTH +: WIDTH];
            end
            L_D2: begin
                for (int unsigned i = 0; i < N_D_L2; i++)
                    if (nxt_idx == IDX_W'(i)) nxt_word = bd2[i*WIDTH +: WIDTH];
            end
            default: begin
                for (int unsigned i = 0; i < N_D_L3; i++)
                    if (nxt_idx == IDX_W'(i)) nxt_word = bd3[i*WIDTH +: WIDTH];
            end
        endcase
    end

    // Sequencer FSM with registered data, tags and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_r     <= M_FULL;
            mem_choice <= 1'b0;
            bias_data  <= '0;
            bias_valid <= 1'b0;
            bias_layer <= '0;
            bias_idx   <= '0;
            layer_last <= 1'b0;
            seq_last   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort && (state == S_LOAD || state == S_STREAM)) begin
            // mem_choice deliberately keeps its value across an abort
            state      <= S_IDLE;
            bias_data  <= '0;
            bias_valid <= 1'b0;
            bias_layer <= '0;
            bias_idx   <= '0;
            layer_last <= 1'b0;
            seq_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        mem_choice <= sel_in;
                        mode_r     <= (mode == 2'b11) ? M_FULL : mode;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    bias_data  <= nxt_word;
                    bias_layer <= nxt_layer;
                    bias_idx   <= nxt_idx;
                    layer_last <= nxt_layer_last;
                    seq_last   <= nxt_seq_last;
                    bias_valid <= 1'b1;
                    state      <= S_STREAM;
                end
                S_STREAM: begin
                    if (hs) begin
                        if (seq_last) begin
                            bias_valid <= 1'b0;
                            busy       <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            bias_data  <= nxt_word;
                            bias_layer <= nxt_layer;
                            bias_idx   <= nxt_idx;
                            layer_last <= nxt_layer_last;
                            seq_last   <= nxt_seq_last;
                        end
                    end
                end
                default: begin
                    // done is raised on the first DONE cycle and dropped on
                    // the second, which is also when IDLE is re-entered
                    if (!done) begin
                        done <= 1'b1;
                    end else begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gan_bias_seq.sv
// Scoreboard bench for gan_bias_seq: a combinational two-set bias memory
// model, directed sequences, and a negedge monitor popping expected words.
module tb_gan_bias_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, sel_in, abort, bias_ready;
    logic [1:0]  mode;
    logic [95:0] bg2;
    logic [287:0] bg3;
    logic [95:0] bd2;
    logic [31:0] bd3;
    logic        mem_choice, bias_valid, layer_last, seq_last, busy, done;
    logic [31:0] bias_data;
    logic [1:0]  bias_layer;
    logic [3:0]  bias_idx;

    gan_bias_seq #(.WIDTH(32), .N_G_L2(3), .N_G_L3(9), .N_D_L2(3), .N_D_L3(1), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_in(sel_in), .mode(mode), .abort(abort),
        .bg2(bg2), .bg3(bg3), .bd2(bd2), .bd3(bd3),
        .mem_choice(mem_choice), .bias_data(bias_data), .bias_valid(bias_valid),
        .bias_ready(bias_ready), .bias_layer(bias_layer), .bias_idx(bias_idx),
        .layer_last(layer_last), .seq_last(seq_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Bias words in stream order: G_L2[0..2], G_L3[0..8], D_L2[0..2], D_L3[0]
    logic [31:0] mem0 [16] = '{
        32'h01A1B251, 32'h00C3D2E1, 32'hFFE81A37, 32'h0163E32C,
        32'hFF9A0C11, 32'h00452B7E, 32'hFEDC3301, 32'h0012AB9F,
        32'h00F00F0F, 32'hFF7755AA, 32'h0033CC21, 32'h01374BD8,
        32'h00ABCDEF, 32'hFF123456, 32'h0055AA55, 32'hFF0AB782};
    logic [31:0] mem1 [16] = '{
        32'h00778899, 32'hFF1100EE, 32'hFEC6FD9C, 32'h0089ABCD,
        32'hFF0F1E2D, 32'h003C4B5A, 32'hFE112233, 32'h00445566,
        32'hFF998877, 32'h00BADC0F, 32'h01020304, 32'hFE6E7E6F,
        32'hFF223F6F, 32'hFCFA3A3D, 32'h00060D6D, 32'hFF43FC67};
    int cnt [4] = '{3, 9, 3, 1};
    int off [4] = '{0, 3, 12, 15};

    // Combinational bias memory driven by the DUT's choice select
    always_comb begin
        bg2 = '0; bg3 = '0; bd2 = '0; bd3 = '0;
        for (int i = 0; i < 3; i++) bg2[i*32 +: 32] = mem_choice ? mem1[i]    : mem0[i];
        for (int i = 0; i < 9; i++) bg3[i*32 +: 32] = mem_choice ? mem1[3+i]  : mem0[3+i];
        for (int i = 0; i < 3; i++) bd2[i*32 +: 32] = mem_choice ? mem1[12+i] : mem0[12+i];
        bd3 = mem_choice ? mem1[15] : mem0[15];
    end

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  layer;
        logic [3:0]  idx;
        logic        ll;
        logic        sl;
        logic        ch;
    } exp_t;

    exp_t sb [$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_hs = 0;
    int done_seen = 0;
    int exp_done = 0;
    int nword = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_words(input logic sel, input logic [1:0] md);
        int first, last;
        logic [31:0] w;
        exp_t e;
        first = (md == 2'b10) ? 2 : 0;
        last  = (md == 2'b01) ? 1 : 3;
        for (int l = first; l <= last; l++) begin
            for (int i = 0; i < cnt[l]; i++) begin
                w = sel ? mem1[off[l]+i] : mem0[off[l]+i];
                e.data  = w;
                e.layer = 2'(l);
                e.idx   = 4'(i);
                e.ll    = (i == cnt[l]-1);
                e.sl    = (i == cnt[l]-1) && (l == last);
                e.ch    = sel;
                sb.push_back(e);
            end
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: count done pulses and compare every handshaken word
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                done_seen++;
                chk("done one cycle after last handshake", cyc, last_hs + 1);
            end
            if (bias_valid && bias_ready && !abort) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected word actual=%h required=none", bias_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("w%0d data", nword), bias_data, e.data);
                    chk($sformatf("w%0d layer", nword), 32'(bias_layer), 32'(e.layer));
                    chk($sformatf("w%0d idx", nword), 32'(bias_idx), 32'(e.idx));
                    chk($sformatf("w%0d layer_last", nword), 32'(layer_last), 32'(e.ll));
                    chk($sformatf("w%0d seq_last", nword), 32'(seq_last), 32'(e.sl));
                    chk($sformatf("w%0d mem_choice", nword), 32'(mem_choice), 32'(e.ch));
                    if (e.sl) last_hs = cyc + 1;
                    nword++;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, " mem_choice"}, 32'(mem_choice), 0);
        chk({tag, " bias_data"}, bias_data, 0);
        chk({tag, " bias_valid"}, 32'(bias_valid), 0);
        chk({tag, " bias_layer"}, 32'(bias_layer), 0);
        chk({tag, " bias_idx"}, 32'(bias_idx), 0);
        chk({tag, " layer_last"}, 32'(layer_last), 0);
        chk({tag, " seq_last"}, 32'(seq_last), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
    endtask

    // Pulse start at a negedge; returns at #1 after the sampling edge
    task automatic start_seq(input logic sel, input logic [1:0] md, input string tag);
        @(negedge clk);
        start = 1'b1; sel_in = sel; mode = md;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, " busy after start"}, 32'(busy), 1);
        chk({tag, " mem_choice after start"}, 32'(mem_choice), 32'(sel));
        chk({tag, " valid low in LOAD"}, 32'(bias_valid), 0);
    endtask

    task automatic wait_done(input int budget, input int exp_i, input string tag);
        int i;
        bit found;
        found = 0;
        exp_done++;
        for (i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (done) begin found = 1; break; end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s done timeout actual=none required=pulse", tag);
        end else begin
            if (exp_i > 0) chk({tag, " done cycle"}, 32'(i), 32'(exp_i));
            chk({tag, " busy during done"}, 32'(busy), 0);
            @(posedge clk); #1;
            chk({tag, " done width"}, 32'(done), 0);
        end
    endtask

    task automatic wait_word(input logic [1:0] l, input logic [3:0] ix, input string tag);
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (bias_valid && bias_layer == l && bias_idx == ix) begin found = 1; break; end
            @(posedge clk); #1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL %s word not reached actual=none required=L%0d/%0d", tag, l, ix);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int ds;
        rst = 1'b1; start = 1'b0; sel_in = 1'b0; mode = 2'b00; abort = 1'b0; bias_ready = 1'b1;
        #12;
        chk_all_zero("reset");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // Full mode, set 0, exact timing
        push_words(1'b0, 2'b00);
        start_seq(1'b0, 2'b00, "full");
        @(posedge clk); #1;
        chk("full first valid", 32'(bias_valid), 1);
        chk("full first word", bias_data, 32'h01A1B251);
        wait_done(40, 17, "full");

        // Discriminator only, set 1
        push_words(1'b1, 2'b10);
        start_seq(1'b1, 2'b10, "disc");
        wait_done(20, 6, "disc");

        // Generator only, set 1, stall at word 2
        push_words(1'b1, 2'b01);
        start_seq(1'b1, 2'b01, "gen");
        wait_word(2'd0, 4'd2, "gen stall");
        bias_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d data", s), bias_data, 32'hFEC6FD9C);
            chk($sformatf("stall%0d valid", s), 32'(bias_valid), 1);
            chk($sformatf("stall%0d tags", s),
                32'({bias_layer, bias_idx, layer_last, seq_last}), 32'({2'd0, 4'd2, 1'b1, 1'b0}));
        end
        bias_ready = 1'b1;
        wait_done(30, 0, "gen");

        // Abort during word 5 of a full sequence
        push_words(1'b0, 2'b00);
        start_seq(1'b0, 2'b00, "abort");
        wait_word(2'd1, 4'd2, "abort");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        sb.delete();
        chk("abort valid", 32'(bias_valid), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort tags", 32'({bias_layer, bias_idx, layer_last, seq_last}), 0);
        chk("abort mem_choice hold", 32'(mem_choice), 0);
        ds = done_seen;
        repeat (22) @(posedge clk);
        #1;
        chk("abort no done", 32'(done_seen), 32'(ds));
        push_words(1'b0, 2'b00);
        start_seq(1'b0, 2'b00, "restart");
        @(posedge clk); #1;
        chk("restart first word", bias_data, 32'h01A1B251);
        wait_done(40, 17, "restart");

        // Start and sel_in toggles mid-sequence are ignored
        push_words(1'b0, 2'b00);
        start_seq(1'b0, 2'b00, "ignore");
        repeat (3) @(posedge clk);
        #1;
        sel_in = 1'b1; mode = 2'b10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sel_in = 1'b0; mode = 2'b00;
        chk("ignore mem_choice", 32'(mem_choice), 0);
        chk("ignore busy", 32'(busy), 1);
        wait_done(40, 0, "ignore");

        // Start with abort in IDLE is ignored
        @(negedge clk);
        start = 1'b1; abort = 1'b1; sel_in = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0; sel_in = 1'b0;
        chk("start+abort busy", 32'(busy), 0);
        @(posedge clk); #1;
        chk("start+abort valid", 32'(bias_valid), 0);
        chk("start+abort mem_choice", 32'(mem_choice), 0);

        // Asynchronous reset mid-stream
        push_words(1'b1, 2'b00);
        start_seq(1'b1, 2'b00, "arst");
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk_all_zero("async reset");
        sb.delete();
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("post reset busy", 32'(busy), 0);
        chk("post reset valid", 32'(bias_valid), 0);

        // IDLE after reset: a short sequence runs normally
        push_words(1'b0, 2'b10);
        start_seq(1'b0, 2'b10, "post");
        wait_done(20, 6, "post");

        chk("done count", 32'(done_seen), 32'(exp_done));
        chk("scoreboard empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gan_bias_seq.md
# gan_bias_seq

Bias-fetch sequencer for the GAN inference datapath. On a start request it latches a bias-set choice, drives the `choice` select of the bias memory, and streams the selected bias words one per handshake. The streaming order runs layer by layer (generator L2, generator L3, discriminator L2, discriminator L3), with layer and neuron tags for the downstream neuron/MAC units. It sits between the top-level inference controller and the combinational bias memory.

## Interface
- WIDTH, 32, bias word width (signed fixed point)
- N_G_L2, 3, generator layer-2 neuron count
- N_G_L3, 9, generator layer-3 neuron count
- N_D_L2, 3, discriminator layer-2 neuron count
- N_D_L3, 1, discriminator layer-3 neuron count
- IDX_W, 4, neuron index width (must hold max layer count − 1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a sequence (sampled only in IDLE)
- sel_in  in  1  bias set to use, latched on accepted start
- mode  in  2  00 full G+D, 01 generator only, 10 discriminator only, 11 treated as 00
- abort  in  1  terminate current sequence
- bg2  in  N_G_L2*WIDTH  generator L2 biases from bias memory, word i at [i*WIDTH +: WIDTH]
- bg3  in  N_G_L3*WIDTH  generator L3 biases, same packing
- bd2  in  N_D_L2*WIDTH  discriminator L2 biases
- bd3  in  N_D_L3*WIDTH  discriminator L3 biases
- mem_choice  out  1  select driven to bias memory `choice`
- bias_data  out  WIDTH  current bias word
- bias_valid  out  1  bias_data valid
- bias_ready  in  1  consumer accepts word
- bias_layer  out  2  0 G_L2, 1 G_L3, 2 D_L2, 3 D_L3
- bias_idx  out  IDX_W  neuron index within layer
- layer_last  out  1  current word is last of its layer
- seq_last  out  1  current word is last of sequence
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse on normal completion

## Operation
- States: IDLE, LOAD, STREAM, DONE.
- IDLE: on start=1 and abort=0, latch sel_in into mem_choice and mode into an internal register, then go to LOAD. Start with abort=1 is ignored. Start outside IDLE is ignored. Changes to sel_in or mode while busy have no effect.
- LOAD: one settle cycle for the bias memory. Set the layer pointer to the first layer for the mode (G_L2 for 00/01/11, D_L2 for 10) and idx to 0. Register the first word. Assert bias_valid. Go to STREAM.
- STREAM: the handshake fires when bias_valid & bias_ready.
  - Without a handshake, bias_data and all tags hold stable.
  - On a handshake:
    - Non-final word in a layer: idx+1, and the next word is registered in the same edge.
    - Final word in a layer (idx = N−1): advance to the next layer with idx 0.
    - Final word of the sequence (seq_last): bias_valid drops and the FSM goes to DONE.
- Layer end per mode: 01 ends after G_L3; 00/11 and 10 end after D_L3.
- Word count per mode: 00 = 16, 01 = 12, 10 = 4.
- DONE: done=1 for one cycle, then IDLE. busy is 0 in IDLE and DONE.
- abort=1 in LOAD/STREAM forces IDLE on the next edge:
  - bias_valid, busy and tags are cleared.
  - No done pulse is issued.
  - mem_choice holds its last value.
- Tags are registered alongside bias_data. layer_last = (idx = N_layer−1). seq_last = layer_last & final layer.
- Reset values (any state, including mid-sequence): state IDLE; every output 0, including mem_choice, bias_data, bias_valid, bias_layer, bias_idx, layer_last, seq_last, busy and done.

## Timing
- start sampled at edge k: busy=1 and mem_choice updated after edge k; LOAD occupies cycle k→k+1.
- bias_valid first high after edge k+1.
- With bias_ready held 1, one word per cycle, no bubbles, including across layer boundaries.
- Full mode: handshakes at edges k+2..k+17; done high after edge k+18; IDLE after edge k+19.
- A new start is accepted no earlier than the IDLE cycle following done.
- Latency from an accepted word to the next valid word: 0 cycles.

## Test plan
- Reset, then sel_in=0, mode=00, bias_ready=1, start pulse. Required: 16 words in order.
  - word0 = 0x01A1B251 (layer 0, idx 0).
  - word3 = 0x0163E32C (layer 1, idx 0, layer_last=0).
  - word11 = 0x01374BD8 (layer_last=1).
  - word15 = 0xFF0AB782 (layer 3, seq_last=1).
  - done exactly one cycle after the last handshake.
- sel_in=1, mode=10. Required: 0xFF223F6F, 0xFCFA3A3D, 0x00060D6D, 0xFF43FC67 with layers 2, 2, 2, 3; mem_choice=1 throughout.
- mode=01, sel_in=1, bias_ready low for 3 cycles at word 2 (0xFEC6FD9C). Required: data and tags stable while stalled; 12 words total, last = 0xFE6E7E6F with seq_last=1.
- Abort during word 5 of a full sequence. Required: bias_valid=0 and busy=0 the next cycle, no done pulse; a fresh start then begins again at 0x01A1B251.
- Start pulse and sel_in toggles mid-sequence. Required: ignored, mem_choice unchanged. Start together with abort in IDLE: ignored, busy stays 0.
- Assert rst asynchronously mid-stream (between edges). Required: all outputs 0 immediately, FSM in IDLE.
